// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int DATA_W   = 16;
  localparam int WAIT_DEF = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte of a memory read and sign/zero extends it.
module load_extend
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_byte,
  input  logic              i_signed,
  output logic [DATA_W-1:0] o_result
);

  logic [7:0] w_b;

  assign w_b = i_data[15:8];

  always_comb begin
    o_result = i_data;
    if (i_byte) begin
      o_result = i_signed ? {{8{w_b[7]}}, w_b}
                          : {8'h00, w_b};
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: sequences dataMemory strobes, one response per request.
// Define LSU_ALIGN_CHECK_EN to reject odd-address word accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_DEF,
  parameter int TAG_W       = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_rd,
  output logic              rsp_valid,
  output logic              rsp_load,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [TAG_W-1:0]  rsp_rd,
  output logic              rsp_err,
  output logic              memoryRead,
  output logic              memoryWrite,
  output logic              sb,
  output logic [DATA_W-1:0] address,
  output logic [DATA_W-1:0] dataWrite,
  input  logic [DATA_W-1:0] dataRead
);

  localparam int CNT_W =
    (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  lsu_state_t       r_state;
  logic             r_write;
  logic             r_byte;
  logic             r_signed;
  logic [TAG_W-1:0] r_rd;
  logic [CNT_W-1:0] r_cnt;

  logic              w_accept;
  logic              w_misalign;
  logic [DATA_W-1:0] w_ext;

  assign w_accept = req_valid & req_ready;

`ifdef LSU_ALIGN_CHECK_EN
  assign w_misalign = ~req_byte & req_addr[0];
`else
  assign w_misalign = 1'b0;
`endif

  load_extend u_ext (
    .i_data   (dataRead),
    .i_byte   (r_byte),
    .i_signed (r_signed),
    .o_result (w_ext)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_write     <= 1'b0;
      r_byte      <= 1'b0;
      r_signed    <= 1'b0;
      r_rd        <= '0;
      r_cnt       <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_load    <= 1'b0;
      rsp_rdata   <= '0;
      rsp_rd      <= '0;
      rsp_err     <= 1'b0;
      memoryRead  <= 1'b0;
      memoryWrite <= 1'b0;
      sb          <= 1'b0;
      address     <= '0;
      dataWrite   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      unique case (r_state)
        IDLE, RESP: begin
          req_ready   <= 1'b1;
          memoryRead  <= 1'b0;
          memoryWrite <= 1'b0;
          sb          <= 1'b0;
          address     <= '0;
          dataWrite   <= '0;
          r_state     <= IDLE;
          if (w_accept) begin
            r_write  <= req_write;
            r_byte   <= req_byte;
            r_signed <= req_signed;
            r_rd     <= req_rd;
            r_cnt    <= CNT_W'(WAIT_CYCLES);
            if (w_misalign) begin
              r_state   <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_load  <= 1'b0;
              rsp_rdata <= '0;
              rsp_rd    <= req_rd;
            end else begin
              r_state     <= ACCESS;
              req_ready   <= 1'b0;
              address     <= req_addr;
              memoryRead  <= ~req_write;
              memoryWrite <= req_write;
              sb          <= req_write & req_byte;
              if (req_write) begin
                dataWrite <= req_byte
                  ? {8'h00, req_wdata[7:0]}
                  : req_wdata;
              end
            end
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt - CNT_W'(1);
          // last strobe cycle: capture data, drop strobes
          if (r_cnt == '0) begin
            r_state     <= RESP;
            req_ready   <= 1'b1;
            memoryRead  <= 1'b0;
            memoryWrite <= 1'b0;
            sb          <= 1'b0;
            address     <= '0;
            dataWrite   <= '0;
            rsp_valid   <= 1'b1;
            rsp_load    <= ~r_write;
            rsp_rd      <= r_rd;
            rsp_rdata   <= r_write ? '0 : w_ext;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level model.
module tb_load_store_unit;

  localparam int W  = 2;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic          req_byte = 1'b0;
  logic          req_signed = 1'b0;
  logic [15:0]   req_addr = '0;
  logic [15:0]   req_wdata = '0;
  logic [TW-1:0] req_rd = '0;
  logic          rsp_valid;
  logic          rsp_load;
  logic [15:0]   rsp_rdata;
  logic [TW-1:0] rsp_rd;
  logic          rsp_err;
  logic          memoryRead;
  logic          memoryWrite;
  logic          sb;
  logic [15:0]   address;
  logic [15:0]   dataWrite;
  logic [15:0]   dataRead;

  always #5 clk = ~clk;

  load_store_unit #(.WAIT_CYCLES(W), .TAG_W(TW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_byte(req_byte),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_load(rsp_load),
    .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd),
    .rsp_err(rsp_err), .memoryRead(memoryRead),
    .memoryWrite(memoryWrite), .sb(sb),
    .address(address), .dataWrite(dataWrite),
    .dataRead(dataRead)
  );

  // dataMemory environment
  logic [7:0]  mem  [0:65535];
  logic [7:0]  refm [0:65535];
  logic [15:0] a1;
  assign a1 = address + 16'd1;
  assign dataRead = {mem[address], mem[a1]};
  always @(posedge clk) begin
    if (memoryWrite) begin
      mem[address] <= sb ? dataWrite[7:0] : dataWrite[15:8];
      if (!sb) mem[a1] <= dataWrite[7:0];
    end
  end

  int vectors = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // transaction-level model state
  int cyc = 0;
  int acc_lo = 0, acc_hi = -1, rsp_at = -1, acc_cyc = 0;
  int n_acc = 0, n_rsp = 0;
  logic          t_write = 0, t_byte = 0, t_err = 0;
  logic [15:0]   t_addr = '0, t_wdata = '0;
  logic [15:0]   e_rdata = '0, last_rdata = '0;
  logic          e_load = 0, last_load = 0;
  logic [TW-1:0] e_rd = '0, last_rd = '0;
  logic [15:0]   cap_rdata = '0;
  logic          cap_load = 0, cap_err = 0;
  logic [TW-1:0] cap_rd = '0;

  always @(negedge clk) begin : model
    logic in_acc, in_rsp;
    logic [15:0] ew, wd;
    logic [7:0] b;
    if (!reset_n) begin
      acc_lo = 0; acc_hi = -1; rsp_at = -1;
      last_rdata = '0; last_load = 0; last_rd = '0;
      n_acc = n_rsp;
      chk("rst_ready", 16'(req_ready), 16'd1);
      chk("rst_strobes", {11'd0, memoryRead, memoryWrite, sb,
                          rsp_valid, rsp_err}, 16'd0);
      chk("rst_address", address, 16'd0);
      chk("rst_dataWrite", dataWrite, 16'd0);
      chk("rst_rdata", rsp_rdata, 16'd0);
      chk("rst_rsp", {11'd0, rsp_load, 4'(rsp_rd)}, 16'd0);
    end else begin
      in_acc = cyc >= acc_lo && cyc <= acc_hi;
      in_rsp = cyc == rsp_at;
      ew = t_byte ? {8'h00, t_wdata[7:0]} : t_wdata;
      chk("req_ready", 16'(req_ready), 16'(!in_acc));
      chk("memoryRead", 16'(memoryRead), 16'(in_acc && !t_write));
      chk("memoryWrite", 16'(memoryWrite), 16'(in_acc && t_write));
      chk("sb", 16'(sb), 16'(in_acc && t_write && t_byte));
      chk("address", address, in_acc ? t_addr : 16'd0);
      chk("dataWrite", dataWrite, (in_acc && t_write) ? ew : 16'd0);
      if (in_acc && cyc == acc_lo && t_write) begin
        refm[t_addr] = t_byte ? t_wdata[7:0] : t_wdata[15:8];
        if (!t_byte) refm[t_addr + 16'd1] = t_wdata[7:0];
      end
      if (in_rsp) begin
        last_rdata = e_rdata; last_load = e_load; last_rd = e_rd;
        cap_rdata = rsp_rdata; cap_load = rsp_load;
        cap_rd = rsp_rd; cap_err = rsp_err;
        n_rsp++;
      end
      chk("rsp_valid", 16'(rsp_valid), 16'(in_rsp));
      chk("rsp_err", 16'(rsp_err), 16'(in_rsp && t_err));
      chk("rsp_rdata", rsp_rdata, last_rdata);
      chk("rsp_load", 16'(rsp_load), 16'(last_load));
      chk("rsp_rd", 16'(rsp_rd), 16'(last_rd));
      if (!in_acc && req_valid) begin
        t_write = req_write; t_byte = req_byte;
        t_addr = req_addr; t_wdata = req_wdata;
        e_rd = req_rd; acc_cyc = cyc; n_acc++;
        t_err = 0;
`ifdef LSU_ALIGN_CHECK_EN
        t_err = !req_byte && req_addr[0];
`endif
        if (t_err) begin
          acc_lo = cyc + 1; acc_hi = cyc; rsp_at = cyc + 1;
          e_rdata = '0; e_load = 0;
        end else begin
          acc_lo = cyc + 1; acc_hi = cyc + 1 + W;
          rsp_at = cyc + 2 + W;
          b  = refm[req_addr];
          wd = {b, refm[req_addr + 16'd1]};
          e_load = !req_write;
          if (req_write) e_rdata = '0;
          else if (!req_byte) e_rdata = wd;
          else if (req_signed) e_rdata = 16'($signed(b));
          else e_rdata = {8'h00, b};
        end
      end
    end
    cyc++;
  end

  // called in the phase just after a rising edge
  task automatic issue(input logic w, input logic bt, input logic s,
                       input logic [15:0] a, input logic [15:0] d,
                       input logic [TW-1:0] rd);
    int n0;
    n0 = n_acc;
    req_valid = 1; req_write = w; req_byte = bt; req_signed = s;
    req_addr = a; req_wdata = d; req_rd = rd;
    for (int i = 0; i < 60 && n_acc == n0; i++) begin
      @(posedge clk); #1;
    end
    if (n_acc == n0) begin
      vectors++; errs++;
      $display("FAIL accept_timeout: got none expected accept");
    end
    req_valid = 0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 60 && n_rsp < n_acc; i++) begin
      @(posedge clk); #1;
    end
    if (n_rsp < n_acc) begin
      vectors++; errs++;
      $display("FAIL rsp_timeout: got %0d expected %0d", n_rsp, n_acc);
    end
  endtask

  int c0, gap;
  logic [15:0] ra;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      refm[i] = mem[i];
    end
    mem[16'h0010] = 8'h9C; refm[16'h0010] = 8'h9C;
    mem[16'h0021] = 8'h77; refm[16'h0021] = 8'h77;
    mem[16'h0003] = 8'h11; refm[16'h0003] = 8'h11;
    mem[16'h0004] = 8'h22; refm[16'h0004] = 8'h22;
    mem[16'h0030] = 8'h12; refm[16'h0030] = 8'h12;
    mem[16'h0031] = 8'h34; refm[16'h0031] = 8'h34;
    mem[16'hFFFF] = 8'h5A; refm[16'hFFFF] = 8'h5A;
    mem[16'h0000] = 8'hC3; refm[16'h0000] = 8'hC3;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    @(posedge clk); #1;

    issue(1, 0, 0, 16'hFFFA, 16'h0045, 4'd3); wait_rsp();
    chk("store_rsp_load", 16'(cap_load), 16'd0);
    issue(0, 0, 0, 16'hFFFA, 16'h0000, 4'd5); wait_rsp();
    chk("word_load", cap_rdata, 16'h0045);
    chk("word_load_rd", 16'(cap_rd), 16'd5);
    issue(0, 1, 1, 16'h0010, 16'h0000, 4'd1); wait_rsp();
    chk("byte_signed", cap_rdata, 16'hFF9C);
    issue(0, 1, 0, 16'h0010, 16'h0000, 4'd2); wait_rsp();
    chk("byte_unsigned", cap_rdata, 16'h009C);
    issue(1, 1, 0, 16'h0020, 16'hAB12, 4'd1); wait_rsp();
    issue(0, 0, 0, 16'h0020, 16'h0000, 4'd7); wait_rsp();
    chk("byte_store_readback", cap_rdata, 16'h1277);
    issue(0, 0, 0, 16'hFFFF, 16'h0000, 4'd8); wait_rsp();
    issue(0, 0, 0, 16'h0003, 16'h0000, 4'd9); wait_rsp();
`ifdef LSU_ALIGN_CHECK_EN
    chk("misalign_err", 16'(cap_err), 16'd1);
    chk("misalign_rdata", cap_rdata, 16'h0000);
`else
    chk("odd_word_load", cap_rdata, 16'h1122);
    chk("odd_word_err", 16'(cap_err), 16'd0);
`endif

    // back-to-back accepts
    issue(0, 1, 0, 16'h0004, 16'h0000, 4'd4);
    c0 = acc_cyc;
    issue(0, 1, 0, 16'h0003, 16'h0000, 4'd6);
    chk("b2b_spacing", 16'(acc_cyc - c0), 16'(W + 2));
    wait_rsp();

    // reset in the middle of a store
    issue(1, 0, 0, 16'h0030, 16'hBEEF, 4'd2);
    reset_n = 0; #1;
    chk("rst_mid_memoryWrite", 16'(memoryWrite), 16'd0);
    chk("rst_mid_ready", 16'(req_ready), 16'd1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    @(posedge clk); #1;
    issue(0, 0, 0, 16'h0030, 16'h0000, 4'd3); wait_rsp();
    chk("rst_dropped_store", cap_rdata, 16'h1234);

    for (int k = 0; k < 300; k++) begin
      gap = int'($urandom_range(0, 3));
      repeat (gap) begin @(posedge clk); #1; end
      ra = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                       : 16'($urandom_range(0, 63));
      issue(1'($urandom), 1'($urandom), 1'($urandom), ra,
            16'($urandom), TW'($urandom));
    end
    wait_rsp();
    repeat (4) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage sitting directly upstream of dataMemory. It accepts load/store requests from the execute stage over a valid/ready handshake and sequences the dataMemory strobes (memoryRead, memoryWrite, sb, address, dataWrite).
- It absorbs a configurable memory wait-state count, byte-selects and extends load data, and returns one registered response per request to writeback.

Parameters:
- WAIT_CYCLES, 0: extra cycles the memory strobes are held before read data is captured or the write is considered committed.
- TAG_W, 4: width of the destination-register tag carried with the request.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_write  in  1  1=store, 0=load
- req_byte  in  1  1=byte access, 0=word access
- req_signed  in  1  sign-extend byte load; ignored for word loads and for stores
- req_addr  in  16  byte address
- req_wdata  in  16  store data; byte store uses [7:0]
- req_rd  in  TAG_W  destination tag
- rsp_valid  out  1  one-cycle response pulse
- rsp_load  out  1  response needs register writeback
- rsp_rdata  out  16  extended load data; 0 for stores
- rsp_rd  out  TAG_W  tag of the completed request
- rsp_err  out  1  access rejected
- memoryRead  out  1  to dataMemory
- memoryWrite  out  1  to dataMemory
- sb  out  1  to dataMemory, store-byte
- address  out  16  to dataMemory
- dataWrite  out  16  to dataMemory
- dataRead  in  16  from dataMemory

Behaviour:
- **Memory contract:**
  - Read at a returns {M[a],M[a+1]} combinationally.
  - A word write commits M[a]=dataWrite[15:8], M[a+1]=dataWrite[7:0] on every rising edge with memoryWrite=1.
  - With sb=1, a write commits only M[a]=dataWrite[7:0].
- **States:** IDLE, ACCESS, RESP.
- **Reset (asynchronous, applies from any state):**
  - State goes to IDLE.
  - All outputs are 0 except req_ready=1.
  - An in-flight request is dropped. Strobes fall immediately, so no further write edge occurs.
- **IDLE:**
  - req_ready=1.
  - On req_valid & req_ready, latch write, byte, signed, addr, wdata and rd.
  - Load wait counter = WAIT_CYCLES.
  - Go to ACCESS.
- **ACCESS:**
  - req_ready=0.
  - address = latched addr.
  - Load: memoryRead=1.
  - Store: memoryWrite=1, sb = latched byte, dataWrite = byte ? {8'h00,wdata[7:0]} : wdata.
  - Counter decrements each cycle.
  - On the edge where counter==0, capture the extended dataRead into rsp_rdata (stores capture 0), then go to RESP.
  - Strobes are held for exactly WAIT_CYCLES+1 cycles. Repeated identical write edges are harmless.
- **RESP:**
  - rsp_valid=1 for exactly one cycle.
  - rsp_load = !write; rsp_rd = latched rd.
  - All memory strobes, address and dataWrite are 0.
  - req_ready=1, so a new request may be accepted in RESP (RESP→ACCESS).
  - Otherwise go to IDLE.
- **Response outputs outside RESP:** rsp_rdata, rsp_rd and rsp_load hold their last values. rsp_valid and rsp_err are 0.
- **Load extend:**
  - Byte load: b=dataRead[15:8]; result is {{8{b[7]}},b} if signed, else {8'h00,b}.
  - Word load: result is dataRead.
- **Latency:**
  - Accept edge E; rsp_valid is high in the cycle after edge E+1+WAIT_CYCLES.
  - Back-to-back throughput is one request per 2+WAIT_CYCLES cycles.
- **No response backpressure:** writeback always accepts rsp_valid.
- **Idle outputs:** in IDLE with no request, memoryRead, memoryWrite, sb, address and dataWrite are all 0.
- **Address wrap:** req_addr=16'hFFFF word access is passed through unchanged. Wrap of a+1 is the memory's concern.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined: a word request (req_byte=0) with req_addr[0]=1 goes IDLE→RESP directly, issuing no memory strobes. The response is rsp_err=1, rsp_rdata=0, rsp_load=0.
- Not defined: rsp_err is tied to 0 and odd word accesses proceed normally.

Decomposition:
- Package lsu_pkg holds the state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), the default WAIT_CYCLES and the data width constant 16.
- One combinational sub-module, load_extend: inputs dataRead, byte, signed; output the 16-bit result.

Test Plan:
1. Reset mid-ACCESS: assert reset_n=0 during a store with WAIT_CYCLES=2 → memoryWrite drops the same cycle, state is IDLE, req_ready=1, rsp_valid never pulses.
2. Word store then load, WAIT_CYCLES=0: store 16'h0045 to 16'hFFFA, then load 16'hFFFA → store rsp_valid with rsp_load=0; load rsp_rdata=16'h0045, rsp_rd echoed; two cycles between accepts.
3. Byte loads: M[16'h0010]=8'h9C. Load signed → rsp_rdata=16'hFF9C. Load unsigned → rsp_rdata=16'h009C.
4. Byte store: sb store of req_wdata=16'hAB12 to 16'h0020 → dataWrite=16'h0012, sb=1 for exactly one cycle; subsequent word load returns 16'h12xx with M[16'h0021] unchanged.
5. WAIT_CYCLES=3: load request → memoryRead high exactly 4 cycles, req_ready low throughout, rsp_valid in the 5th cycle after acceptance.
6. LSU_ALIGN_CHECK_EN: word load at 16'h0003 → no memoryRead, rsp_valid with rsp_err=1, rsp_rdata=0 in the cycle after acceptance. Without the macro the same request reads {M[3],M[4]} with rsp_err=0.
